// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer: data width, HALT encoding,
// IMEM geometry and the fetch state encoding.
package imem_fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int MEM_WORDS = 128;
    localparam logic [XLEN-1:0] HALT_INSN = 32'h0000_0063;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_HALTED,
        ST_FAULT
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: IMEM address/data, redirect request from the branch unit, and the
// instruction handshake to decode.
interface imem_fetch_ctrl_if;
    import imem_fetch_ctrl_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    // inst_valid/inst_out/inst_pc stay stable while inst_valid & !inst_ready; a word moves
    // to decode only on a cycle where inst_valid & inst_ready are both high.
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst_out, inst_pc,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_buf.sv
// One-entry instruction buffer (word + its PC). Flush wins over load; an accepted entry
// that is not replaced empties the buffer.
module imem_fetch_ctrl_fetch_buf
    import imem_fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  logic            ready,
    input  logic [XLEN-1:0] load_data,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [XLEN-1:0] data,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, feeds the one-entry buffer from IMEM, applies
// redirects and stops on HALT or on a misaligned redirect target.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    imem_fetch_ctrl_if.master        bus,
    output logic                     halted,
    output logic                     fault,
    output logic [XLEN-1:0]          fetch_count,
    output fetch_state_t             state
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] count_q, count_d;
    logic            halted_q, halted_d;
    logic            load;
    logic            flush;
    logic            accept;

    assign accept = bus.inst_valid & bus.inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        halted_d = halted_q;
        load     = 1'b0;
        flush    = 1'b0;

        // An acceptance counts even when a redirect flushes the buffer in the same cycle.
        if (accept && count_q != '1) begin
            count_d = count_q + 32'd1;
        end

        if (start) begin
            state_d  = ST_FETCH;
            pc_d     = RESET_PC;
            count_d  = '0;
            halted_d = 1'b0;
            flush    = 1'b1;
        end else if (bus.redirect_valid && state_q != ST_IDLE && is_misaligned(bus.redirect_pc)) begin
            state_d = ST_FAULT;
            flush   = 1'b1;
        end else if (bus.redirect_valid && (state_q == ST_FETCH || state_q == ST_DRAIN)) begin
            state_d = ST_FETCH;
            pc_d    = bus.redirect_pc;
            flush   = 1'b1;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!bus.inst_valid || bus.inst_ready) begin
                        load = 1'b1;
                        pc_d = pc_q + 32'd4;
                        if (bus.imem_rdata == HALT_INSN) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                // Only the HALT word can be in the buffer here.
                ST_DRAIN: begin
                    if (accept) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    imem_fetch_ctrl_fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (load),
        .ready     (bus.inst_ready),
        .load_data (bus.imem_rdata),
        .load_pc   (pc_q),
        .valid     (bus.inst_valid),
        .data      (bus.inst_out),
        .pc        (bus.inst_pc)
    );

    assign bus.imem_addr = pc_q;
    assign halted        = halted_q;
    assign fault         = (state_q == ST_FAULT);
    assign fetch_count   = count_q;
    assign state         = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: IMEM array model, expected accepted-PC stream, per-cycle
// compare process and directed scenarios with literal timing expectations.
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            halted;
    logic            fault;
    logic [XLEN-1:0] fetch_count;
    fetch_state_t    state;

    logic [31:0]     mem [MEM_WORDS];
    logic [XLEN-1:0] exp_q [$];
    int              checks = 0;
    int              errors = 0;

    logic [XLEN-1:0] m_count = '0;
    logic            p_valid = 1'b0;
    logic            p_ready = 1'b0;
    logic            p_ctl = 1'b0;
    logic [XLEN-1:0] p_out = '0;
    logic [XLEN-1:0] p_pc = '0;
    logic [XLEN-1:0] e_pc;

    logic [XLEN-1:0] s_out, s_pc, s_addr;

    imem_fetch_ctrl_if bus();

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus.master),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = (bus.imem_addr < 32'(MEM_WORDS * 4)) ? mem[bus.imem_addr[8:2]] : HALT_INSN;

    function automatic logic [31:0] ref_insn(input logic [31:0] a);
        if (a < 32'(MEM_WORDS * 4)) return mem[a[8:2]];
        return HALT_INSN;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: accepted words must follow the expected PC stream, stalled
    // words must hold, and fetch_count must equal the number of acceptances since start.
    always @(negedge clk) begin
        if (rst) begin
            m_count = '0;
            p_valid = 1'b0;
        end else begin
            check("fetch_count", fetch_count, m_count);
            if (p_valid && !p_ready && !p_ctl) begin
                check("stall_valid", 32'(bus.inst_valid), 32'd1);
                check("stall_out", bus.inst_out, p_out);
                check("stall_pc", bus.inst_pc, p_pc);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got pc %h expected none at %0t", bus.inst_pc, $time);
                end else begin
                    e_pc = exp_q.pop_front();
                    check("accept_pc", bus.inst_pc, e_pc);
                    check("accept_insn", bus.inst_out, ref_insn(e_pc));
                end
            end
            if (start) m_count = '0;
            else if (bus.inst_valid && bus.inst_ready && m_count != '1) m_count = m_count + 1;
            p_valid = bus.inst_valid;
            p_ready = bus.inst_ready;
            p_ctl   = start | bus.redirect_valid;
            p_out   = bus.inst_out;
            p_pc    = bus.inst_pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_halted(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        fill_mem();
        #12 rst = 1'b0;
        tick();

        // Reset state
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_out", bus.inst_out, 32'd0);
        check("rst_pc", bus.inst_pc, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));

        // 1: straight-line to HALT
        mem[0] = 32'h0000_0013; mem[1] = 32'h0000_0013;
        mem[2] = 32'h0000_0013; mem[3] = 32'h0000_0013;
        mem[4] = 32'h0000_0063;
        bus.inst_ready = 1'b1;
        push_seq(32'h0, 5);
        do_start();
        check("t1_gap_valid", 32'(bus.inst_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t1_valid", 32'(bus.inst_valid), 32'd1);
            check("t1_pc", bus.inst_pc, 32'(4 * k));
            check("t1_not_halted", 32'(halted), 32'd0);
        end
        tick();
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_count", fetch_count, 32'd5);
        check("t1_valid_off", 32'(bus.inst_valid), 32'd0);
        tick();
        check("t1_halted_hold", 32'(halted), 32'd1);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // 2: backpressure on pc 8
        fill_mem();
        mem[6] = HALT_INSN;
        push_seq(32'h0, 7);
        do_start();
        tick();
        tick();
        tick();
        check("t2_pc8", bus.inst_pc, 32'd8);
        bus.inst_ready = 1'b0;
        s_out  = bus.inst_out;
        s_pc   = bus.inst_pc;
        s_addr = bus.imem_addr;
        check("t2_addr", s_addr, 32'd12);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_hold_out", bus.inst_out, s_out);
            check("t2_hold_pc", bus.inst_pc, s_pc);
            check("t2_hold_addr", bus.imem_addr, s_addr);
        end
        bus.inst_ready = 1'b1;
        wait_halted(20);
        check("t2_count", fetch_count, 32'd7);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // 3: aligned redirect while pc 8 is accepted
        fill_mem();
        mem[18] = HALT_INSN;
        push_seq(32'h0, 3);
        push_seq(32'h40, 3);
        do_start();
        tick();
        tick();
        tick();
        check("t3_pc8", bus.inst_pc, 32'd8);
        redirect(32'h40);
        check("t3_flush_valid", 32'(bus.inst_valid), 32'd0);
        check("t3_count", fetch_count, 32'd3);
        check("t3_addr", bus.imem_addr, 32'h40);
        tick();
        check("t3_new_valid", 32'(bus.inst_valid), 32'd1);
        check("t3_new_pc", bus.inst_pc, 32'h40);
        wait_halted(20);
        check("t3_final_count", fetch_count, 32'd6);
        check("t3_queue", 32'(exp_q.size()), 32'd0);

        // 4: misaligned redirect, then restart
        fill_mem();
        mem[10] = HALT_INSN;
        push_seq(32'h0, 2);
        do_start();
        tick();
        tick();
        redirect(32'h42);
        for (int k = 0; k < 3; k++) begin
            check("t4_fault", 32'(fault), 32'd1);
            check("t4_valid", 32'(bus.inst_valid), 32'd0);
            check("t4_addr", bus.imem_addr, 32'd8);
            tick();
        end
        check("t4_count", fetch_count, 32'd2);
        push_seq(32'h0, 11);
        do_start();
        check("t4_fault_clr", 32'(fault), 32'd0);
        tick();
        check("t4_resume_pc", bus.inst_pc, 32'd0);
        check("t4_resume_valid", 32'(bus.inst_valid), 32'd1);
        wait_halted(30);
        check("t4_final_count", fetch_count, 32'd11);
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // 5: run off the end of IMEM
        fill_mem();
        mem[127] = 32'h0000_0013;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1FC);
        exp_q.push_back(32'h200);
        do_start();
        tick();
        redirect(32'h1FC);
        tick();
        check("t5_pc_1fc", bus.inst_pc, 32'h1FC);
        check("t5_insn_1fc", bus.inst_out, 32'h0000_0013);
        tick();
        check("t5_pc_200", bus.inst_pc, 32'h200);
        check("t5_insn_200", bus.inst_out, 32'h0000_0063);
        tick();
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_count", fetch_count, 32'd3);
        check("t5_queue", 32'(exp_q.size()), 32'd0);

        // 6: asynchronous reset mid-stream
        fill_mem();
        mem[20] = HALT_INSN;
        push_seq(32'h0, 2);
        do_start();
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("t6_valid", 32'(bus.inst_valid), 32'd0);
        check("t6_out", bus.inst_out, 32'd0);
        check("t6_pc", bus.inst_pc, 32'd0);
        check("t6_addr", bus.imem_addr, 32'd0);
        check("t6_halted", 32'(halted), 32'd0);
        check("t6_fault", 32'(fault), 32'd0);
        check("t6_count", fetch_count, 32'd0);
        check("t6_state", 32'(state), 32'(ST_IDLE));
        check("t6_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        push_seq(32'h0, 21);
        do_start();
        tick();
        check("t6_restart_pc", bus.inst_pc, 32'd0);
        wait_halted(40);
        check("t6_final_count", fetch_count, 32'd21);
        check("t6_final_queue", 32'(exp_q.size()), 32'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
